param_updown_counter: RTL

//  Synchronous, parametrised modulo-N up/down counter.

---
 rtl/param_updown_counter_if.sv | 12 +
 rtl/param_updown_counter.sv | 35 +++
 2 files changed

// File: rtl/param_updown_counter_if.sv
// param_updown_counter_if: control and status bundle for the modulo-N up/down counter
interface param_updown_counter_if #(parameter int WIDTH = 4);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  modport master (output en, up, load, load_val, input q, tc, wrap);
  modport slave  (input en, up, load, load_val, output q, tc, wrap);
endinterface

// File: rtl/param_updown_counter.sv
// param_updown_counter: synchronous modulo-N up/down counter with load, wrap pulse and saturate mode
module param_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input logic                   clk,
  input logic                   reset,
  param_updown_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic             SAT = SATURATE != 0;
  logic             at_top, at_bot, at_bound;
  logic [WIDTH-1:0] q_nxt, ld_val, cnt_val;
  logic             wrap_nxt;
  assign at_top   = bus.q == MAX;
  assign at_bot   = bus.q == '0;
  assign at_bound = bus.up ? at_top : at_bot;
  assign bus.tc   = at_bound;
  always_comb begin
    ld_val   = bus.load_val > MAX ? MAX : bus.load_val;
    cnt_val  = bus.up ? (at_top ? (SAT ? MAX : '0) : bus.q + 1'b1)
                      : (at_bot ? (SAT ? '0 : MAX) : bus.q - 1'b1);
    q_nxt    = bus.load ? ld_val : bus.en ? cnt_val : bus.q;
    wrap_nxt = !bus.load && bus.en && at_bound && !SAT;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.q    <= '0;
      bus.wrap <= 1'b0;
    end else begin
      bus.q    <= q_nxt;
      bus.wrap <= wrap_nxt;
    end
endmodule
